// File: rtl/hls_fp16_to_fp32_core_chn_a_rsci_if.sv
// ---------------------------------------------------------------------------
// hls_fp16_to_fp32_core_chn_a_rsci_if
//
// Purpose: bundles the fp16 input channel of the fp16-to-fp32 core. This
// covers the upstream valid/ready (vz/lz) side and the core-side stall-control
// side (oswt/bawt/wen_comp) into one connection point.
//
// Signals:
//   chn_a_rsc_z          upstream payload (WIDTH bits)
//   chn_a_rsc_vz         upstream valid
//   chn_a_rsc_lz         ready (load) back to upstream
//   chn_a_rsci_oswt      core requests an operand this cycle
//   core_wen             core global enable
//   core_wten            core wait state, blocks consumption
//   chn_a_rsci_bawt      operand available to the core
//   chn_a_rsci_wen_comp  channel does not stall the core
//   chn_a_rsci_d_mxwt    head-of-buffer operand
//
// Modports:
//   slave  - the channel receiver (consumes z/vz, serves the core)
//   master - the environment (upstream producer plus core control)
// ---------------------------------------------------------------------------
interface hls_fp16_to_fp32_core_chn_a_rsci_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] chn_a_rsc_z;
    logic             chn_a_rsc_vz;
    logic             chn_a_rsc_lz;
    logic             chn_a_rsci_oswt;
    logic             core_wen;
    logic             core_wten;
    logic             chn_a_rsci_bawt;
    logic             chn_a_rsci_wen_comp;
    logic [WIDTH-1:0] chn_a_rsci_d_mxwt;

    modport slave (
        input  chn_a_rsc_z,
        input  chn_a_rsc_vz,
        output chn_a_rsc_lz,
        input  chn_a_rsci_oswt,
        input  core_wen,
        input  core_wten,
        output chn_a_rsci_bawt,
        output chn_a_rsci_wen_comp,
        output chn_a_rsci_d_mxwt
    );

    modport master (
        output chn_a_rsc_z,
        output chn_a_rsc_vz,
        input  chn_a_rsc_lz,
        output chn_a_rsci_oswt,
        output core_wen,
        output core_wten,
        input  chn_a_rsci_bawt,
        input  chn_a_rsci_wen_comp,
        input  chn_a_rsci_d_mxwt
    );
endinterface

// File: rtl/hls_fp16_to_fp32_core_chn_a_rsci.sv
// ---------------------------------------------------------------------------
// hls_fp16_to_fp32_core_chn_a_rsci
//
// Purpose: input-channel receiver for the fp16-to-fp32 core. It accepts fp16
// operands from the upstream pipe, buffers them in a small circular store,
// and presents the head entry to the core datapath.
//
// Ports:
//   nvdla_core_clk  core clock, rising edge
//   nvdla_core_rst  asynchronous active-high reset
//   chn             hls_fp16_to_fp32_core_chn_a_rsci_if.slave (see interface)
//
// Configuration macro: HLS_FP16_TO_FP32_CHN_A_SKID_EN
//   defined   - 2-entry skid buffer; lz is a flop with no combinational path
//               from the core side.
//   undefined - 1-entry register; lz passes the pop through combinationally
//               so a full buffer can accept and retire on the same edge.
//
// Handshake semantics:
//   upstream: a word transfers on every rising edge where vz & lz is 1. lz
//             never depends on vz, and the producer holds z stable until the
//             transfer happens.
//   core:     the head entry retires on every rising edge where
//             oswt & core_wen & ~core_wten & bawt is 1. bawt and d_mxwt come
//             from registered state only. wen_comp = ~oswt | bawt tells the
//             core that a requested operand is ready.
// ---------------------------------------------------------------------------
module hls_fp16_to_fp32_core_chn_a_rsci #(
    parameter int WIDTH = 16
) (
    input  logic                                      nvdla_core_clk,
    input  logic                                      nvdla_core_rst,
    hls_fp16_to_fp32_core_chn_a_rsci_if.slave         chn
);

`ifdef HLS_FP16_TO_FP32_CHN_A_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             bawt;
    logic             lz;

    // Pointer advance with explicit wrap, so the store need not be a power
    // of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign bawt = (count != '0);
    assign pop  = chn.chn_a_rsci_oswt & chn.core_wen & ~chn.core_wten & bawt;
    assign push = chn.chn_a_rsc_vz & lz;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_next;
            if (push) begin
                mem[wr_ptr] <= chn.chn_a_rsc_z;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

`ifdef HLS_FP16_TO_FP32_CHN_A_SKID_EN
    // Registered ready: it looks ahead at the post-edge occupancy, so a pop
    // frees a slot one cycle later. At full this means a same-cycle pop
    // cannot admit a new word. The async reset clears it, and it rises on
    // the first edge after release.
    logic lz_q;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            lz_q <= 1'b0;
        end else begin
            lz_q <= (count_next < CNT_W'(2));
        end
    end

    assign lz = lz_q;
`else
    // rst_q keeps ready low through the first edge after reset release.
    // Ready then follows the single slot: free when empty, or when the
    // occupant retires on this same edge.
    logic rst_q;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    assign lz = ~rst_q & ((count == '0) | pop);
`endif

    assign chn.chn_a_rsc_lz        = lz;
    assign chn.chn_a_rsci_bawt     = bawt;
    assign chn.chn_a_rsci_wen_comp = ~chn.chn_a_rsci_oswt | bawt;
    // Popped entries linger in the store, so gate the head with occupancy.
    assign chn.chn_a_rsci_d_mxwt   = bawt ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_hls_fp16_to_fp32_core_chn_a_rsci.sv
// ---------------------------------------------------------------------------
// tb_hls_fp16_to_fp32_core_chn_a_rsci
//
// Directed bench for the fp16 input-channel receiver. It covers reset
// release, streaming, configuration-specific full behaviour, the core wait
// state and mid-operation reset. Expected values are hand-derived per step.
// ---------------------------------------------------------------------------
module tb_hls_fp16_to_fp32_core_chn_a_rsci;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];

    hls_fp16_to_fp32_core_chn_a_rsci_if #(.WIDTH(16)) chn ();

    hls_fp16_to_fp32_core_chn_a_rsci #(.WIDTH(16)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .chn            (chn)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_core(input string tag, input logic exp_bawt, input logic [15:0] exp_d);
        check({tag, "_bawt"}, {15'd0, chn.chn_a_rsci_bawt}, {15'd0, exp_bawt});
        check({tag, "_d"}, chn.chn_a_rsci_d_mxwt, exp_d);
    endtask

    task automatic check_lz(input string tag, input logic exp_lz);
        check({tag, "_lz"}, {15'd0, chn.chn_a_rsc_lz}, {15'd0, exp_lz});
    endtask

    task automatic check_wc(input string tag, input logic exp_wc);
        check({tag, "_wen_comp"}, {15'd0, chn.chn_a_rsci_wen_comp}, {15'd0, exp_wc});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        chn.chn_a_rsc_z     = 16'h3C00;
        chn.chn_a_rsc_vz    = 1'b1;
        chn.chn_a_rsci_oswt = 1'b0;
        chn.core_wen        = 1'b0;
        chn.core_wten       = 1'b0;

        // Reset held for 3 cycles with a word offered.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_lz("rst_hold", 1'b0);
            check_core("rst_hold", 1'b0, 16'h0000);
            check_wc("rst_hold", 1'b1);
        end

        rst = 1'b0;
        #1;
        check_lz("rel_pre_edge", 1'b0);
        tick();
        check_lz("rel_first_edge", 1'b1);
        check_core("rel_first_edge", 1'b0, 16'h0000);
        tick();
        check_core("rel_first_push", 1'b1, 16'h3C00);
`ifdef HLS_FP16_TO_FP32_CHN_A_SKID_EN
        check_lz("rel_first_push", 1'b1);
`else
        check_lz("rel_first_push", 1'b0);
`endif
        chn.chn_a_rsc_vz    = 1'b0;
        chn.chn_a_rsci_oswt = 1'b1;
        chn.core_wen        = 1'b1;
        #1;
        check_wc("pop_3c00", 1'b1);
        tick();
        // Empty request: the core is told to stall.
        check_core("empty_req", 1'b0, 16'h0000);
        check_wc("empty_req", 1'b0);

        // Streaming: the core pops every cycle.
        for (int j = 1; j <= 16; j++) begin
            chn.chn_a_rsc_z  = 16'(j);
            chn.chn_a_rsc_vz = 1'b1;
            #1;
            check_lz("stream_lz", 1'b1);
            check_wc("stream_wc", (j == 1) ? 1'b0 : 1'b1);
            exp_q.push_back(16'(j));
            tick();
            check_core("stream", 1'b1, exp_q.pop_front());
        end
        chn.chn_a_rsc_vz = 1'b0;
        #1;
        check_wc("stream_tail", 1'b1);
        tick();
        check_core("stream_drained", 1'b0, 16'h0000);
        chn.chn_a_rsci_oswt = 1'b0;
        chn.core_wen        = 1'b0;

`ifdef HLS_FP16_TO_FP32_CHN_A_SKID_EN
        // Backpressure: fill both slots with the core disabled.
        chn.chn_a_rsci_oswt = 1'b1;
        chn.chn_a_rsc_vz    = 1'b1;
        chn.chn_a_rsc_z     = 16'hAAAA;
        #1;
        check_lz("bp_first", 1'b1);
        check_wc("bp_first", 1'b0);
        tick();
        chn.chn_a_rsc_z = 16'hBBBB;
        #1;
        check_lz("bp_second", 1'b1);
        check_core("bp_second", 1'b1, 16'hAAAA);
        check_wc("bp_second", 1'b1);
        tick();
        chn.chn_a_rsc_z = 16'hCCCC;
        #1;
        check_lz("bp_full", 1'b0);
        check_core("bp_full", 1'b1, 16'hAAAA);
        tick();
        check_lz("bp_held", 1'b0);
        check_core("bp_held", 1'b1, 16'hAAAA);
        chn.core_wen = 1'b1;
        tick();
        check_core("bp_pop1", 1'b1, 16'hBBBB);
        check_lz("bp_pop1", 1'b1);
        tick();
        chn.chn_a_rsc_vz = 1'b0;
        check_core("bp_pop2", 1'b1, 16'hCCCC);
        tick();
        check_core("bp_pop3", 1'b0, 16'h0000);
        chn.chn_a_rsci_oswt = 1'b0;
        chn.core_wen        = 1'b0;
`else
        // Full single register, then push and pop on the same edge.
        chn.chn_a_rsc_vz = 1'b1;
        chn.chn_a_rsc_z  = 16'h1111;
        #1;
        check_lz("full_push", 1'b1);
        tick();
        check_core("full_1111", 1'b1, 16'h1111);
        check_lz("full_1111", 1'b0);
        chn.chn_a_rsc_z = 16'h2222;
        tick();
        // vz while not ready is ignored.
        check_core("full_ignored", 1'b1, 16'h1111);
        check_lz("full_ignored", 1'b0);
        chn.chn_a_rsci_oswt = 1'b1;
        chn.core_wen        = 1'b1;
        #1;
        check_lz("full_passthru", 1'b1);
        check_wc("full_passthru", 1'b1);
        tick();
        chn.chn_a_rsc_vz    = 1'b0;
        chn.chn_a_rsci_oswt = 1'b0;
        #1;
        check_core("full_swap", 1'b1, 16'h2222);
        check_lz("full_swap", 1'b0);
        chn.chn_a_rsci_oswt = 1'b1;
        tick();
        check_core("full_drain", 1'b0, 16'h0000);
        chn.chn_a_rsci_oswt = 1'b0;
        chn.core_wen        = 1'b0;
`endif

        // Core wait state blocks consumption.
        chn.chn_a_rsc_vz = 1'b1;
        chn.chn_a_rsc_z  = 16'h5A5A;
        tick();
        chn.chn_a_rsc_vz    = 1'b0;
        check_core("wten_load", 1'b1, 16'h5A5A);
        chn.chn_a_rsci_oswt = 1'b1;
        chn.core_wen        = 1'b1;
        chn.core_wten       = 1'b1;
        #1;
        check_wc("wten", 1'b1);
        tick();
        check_core("wten_hold", 1'b1, 16'h5A5A);
        chn.core_wten = 1'b0;
        tick();
        check_core("wten_release", 1'b0, 16'h0000);
        chn.chn_a_rsci_oswt = 1'b0;
        chn.core_wen        = 1'b0;

        // Mid-operation asynchronous reset.
        chn.chn_a_rsc_vz = 1'b1;
        chn.chn_a_rsc_z  = 16'h7777;
        tick();
`ifdef HLS_FP16_TO_FP32_CHN_A_SKID_EN
        chn.chn_a_rsc_z = 16'h8888;
        tick();
`endif
        chn.chn_a_rsc_vz = 1'b0;
        check_core("mid_loaded", 1'b1, 16'h7777);
        #3;
        rst = 1'b1;
        #1;
        check_core("mid_rst_async", 1'b0, 16'h0000);
        check_lz("mid_rst_async", 1'b0);
        check_wc("mid_rst_async", 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_core("mid_rel", 1'b0, 16'h0000);
        check_lz("mid_rel", 1'b1);
        tick();
        check_core("mid_no_ghost", 1'b0, 16'h0000);
        chn.chn_a_rsc_vz = 1'b1;
        chn.chn_a_rsc_z  = 16'h9999;
        tick();
        chn.chn_a_rsc_vz = 1'b0;
        check_core("mid_new", 1'b1, 16'h9999);
        chn.chn_a_rsci_oswt = 1'b1;
        chn.core_wen        = 1'b1;
        tick();
        check_core("mid_final", 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hls_fp16_to_fp32_core_chn_a_rsci.md
# hls_fp16_to_fp32_core_chn_a_rsci

Input-channel receiver for the fp16-to-fp32 HLS core: the consuming end of the same valid/ready (`vz`/`lz`) channel protocol the core uses on its output side. It accepts fp16 operands from the upstream producer through `chn_a_rsc_z`/`vz`/`lz` and buffers them. It presents them to the core datapath with the `oswt`/`bawt`/`wen_comp` stall-control handshake. Sits between the NVDLA upstream pipe and `HLS_fp16_to_fp32_core`, mirroring the output-channel wrapper.

## Interface
- WIDTH, 16, payload width in bits (fp16 operand)
- nvdla_core_clk  in  1  core clock; all state updates on the rising edge
- nvdla_core_rst  in  1  asynchronous, active-high reset
- chn_a_rsc_z  in  WIDTH  upstream payload
- chn_a_rsc_vz  in  1  upstream valid
- chn_a_rsc_lz  out  1  ready to upstream (load)
- chn_a_rsci_oswt  in  1  core requests an operand this cycle
- core_wen  in  1  core global enable
- core_wten  in  1  core in wait state; blocks consumption
- chn_a_rsci_bawt  out  1  operand available to core
- chn_a_rsci_wen_comp  out  1  channel does not stall core: `~oswt | bawt`
- chn_a_rsci_d_mxwt  out  WIDTH  head-of-buffer operand

## Operation
- Push: at a clock edge where `vz & lz` = 1, write `chn_a_rsc_z` at the tail and increment count.
- Pop: at a clock edge where `oswt & core_wen & ~core_wten & bawt` = 1, retire the head entry and decrement count.
- Push and pop on the same edge: count unchanged; the head advances and the new entry goes to the tail.
- `bawt = (count != 0)`. `d_mxwt` shows the head entry, or 0 when empty.
- Buffer is a DEPTH-entry circular store: read/write pointers wrap from DEPTH-1 to 0, and count spans 0..DEPTH.
- No data bypass: an entry pushed on edge N is visible on `d_mxwt`/`bawt` after edge N.
- Empty with `oswt`=1: `wen_comp`=0, no pop, no state change. Data is never dropped or duplicated.
- `vz` while `lz`=0: ignored, with no state change. The upstream holds `z` stable until it is accepted.
- Reset mid-transfer: all buffered entries are discarded. A push in flight on the reset edge is lost; upstream must re-present it.
- Reset values while `nvdla_core_rst`=1: count=0, pointers=0, storage=0, `lz`=0, `bawt`=0, `wen_comp`=`~oswt`, `d_mxwt`=0.

## Timing
- Push-to-available latency: 1 cycle (`vz&lz` at edge N, so `bawt`=1 after edge N).
- Sustained throughput: 1 operand/cycle when the core pops every cycle.
- `bawt`, `d_mxwt`, and `wen_comp` come straight from flops except the `oswt` term of `wen_comp`. No combinational path from `vz`/`z` to the core-side outputs.
- First `lz`=1: after the first rising edge following reset deassertion.

## Configuration
- `HLS_FP16_TO_FP32_CHN_A_SKID_EN` defined:
  - DEPTH=2 skid buffer.
  - `lz` is a flop: next value = (count_next < 2) & ~reset.
  - No combinational path from the core side to `lz`.
  - At full (count=2): `lz`=0, so a same-cycle pop cannot accept.
- `HLS_FP16_TO_FP32_CHN_A_SKID_EN` undefined:
  - DEPTH=1 register.
  - `lz` = `~rst_q & ((count==0) | pop)`, where `rst_q` is a reset flop released on the first edge after deassertion.
  - Gives pop-to-ready combinational pass-through, allowing push+pop on the same edge at full.
- Either configuration sustains 1/cycle.

## Test plan
- Reset release:
  - Hold rst 3 cycles with `vz`=1 and z=0x3C00: `lz`=0 and `bawt`=0 throughout.
  - First edge after release: `lz`=1.
  - Next edge: `bawt`=1 and `d_mxwt`=0x3C00.
- Streaming: push 0x0001..0x0010 back-to-back with `oswt`=`core_wen`=1 and `wten`=0.
  - Core receives all 16 in order, one per cycle after the 1-cycle latency.
  - `wen_comp`=1 after the first word.
- Backpressure (SKID_EN):
  - With `core_wen`=0, push 0xAAAA then 0xBBBB: `lz` drops to 0 after the second push, and a third value 0xCCCC is held off.
  - Raise `core_wen`: pops give 0xAAAA, 0xBBBB, then 0xCCCC.
- Full with simultaneous push/pop (SKID_EN undefined):
  - count=1 (0x1111) and `oswt` pop while `vz`=1 with z=0x2222: `lz`=1 in the same cycle.
  - After the edge: `d_mxwt`=0x2222 and count=1.
- Empty request: `oswt`=1 with an empty buffer: `wen_comp`=0 and `bawt`=0. `core_wten`=1 with data present: no pop, `d_mxwt` holds.
- Mid-operation reset:
  - Two entries buffered, then assert rst asynchronously between edges: `bawt`=0 and `d_mxwt`=0 immediately.
  - After release: the old data never reappears.
